// File: rtl/ternary_dot_stream.sv
// Streaming ternary-weight x binary-activation dot product, BEATS beats of N lanes per result.
// Optional saturating accumulation is enabled by defining TERNARY_DOT_SAT_EN.
module ternary_dot_stream #(
  parameter int unsigned N     = 32,
  parameter int unsigned BEATS = 4,
  parameter int unsigned ACC_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_w_pos,
  input  logic [N-1:0]     in_w_neg,
  input  logic [N-1:0]     in_x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_sat
);

  localparam int unsigned PC_W  = $clog2(N + 1);
  localparam int unsigned BV_W  = PC_W + 1;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic signed [ACC_W-1:0] acc;

  logic [N-1:0]            pos_lanes;
  logic [N-1:0]            neg_lanes;
  logic [PC_W-1:0]         pos_cnt;
  logic [PC_W-1:0]         neg_cnt;
  logic signed [BV_W-1:0]  beat_val;
  logic signed [ACC_W-1:0] sum_c;
  logic                    sat_c;
  logic                    accept;

  // DONE can take a new beat only when the held result is consumed in the same cycle
  assign in_ready  = (state == ACCUM) || out_ready;
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  // Lanes with both masks set cancel out
  assign pos_lanes = in_w_pos & in_x & ~in_w_neg;
  assign neg_lanes = in_w_neg & in_x & ~in_w_pos;

  always_comb begin
    pos_cnt = '0;
    neg_cnt = '0;
    for (int i = 0; i < int'(N); i++) begin
      pos_cnt = pos_cnt + PC_W'(pos_lanes[i]);
      neg_cnt = neg_cnt + PC_W'(neg_lanes[i]);
    end
  end

  assign beat_val = BV_W'(pos_cnt) - BV_W'(neg_cnt);

`ifdef TERNARY_DOT_SAT_EN
  localparam int unsigned SUM_W = ((ACC_W > BV_W) ? ACC_W : BV_W) + 1;
  localparam logic signed [SUM_W-1:0] SUM_MAX =
    {{(SUM_W - ACC_W + 1){1'b0}}, {(ACC_W - 1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SUM_MIN =
    {{(SUM_W - ACC_W + 1){1'b1}}, {(ACC_W - 1){1'b0}}};

  logic signed [SUM_W-1:0] sum_wide;
  logic                    sat_acc;

  // Sum at a width that cannot overflow, then clamp back into ACC_W
  assign sum_wide = SUM_W'(acc) + SUM_W'(beat_val);

  always_comb begin
    sum_c = ACC_W'(sum_wide);
    sat_c = sat_acc;
    if (sum_wide > SUM_MAX) begin
      sum_c = ACC_W'(SUM_MAX);
      sat_c = 1'b1;
    end else if (sum_wide < SUM_MIN) begin
      sum_c = ACC_W'(SUM_MIN);
      sat_c = 1'b1;
    end
  end
`else
  assign sum_c = acc + ACC_W'(beat_val);
  assign sat_c = 1'b0;
`endif

  // acc/cnt are always zero while in DONE, so a beat taken there starts a fresh vector
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ACCUM;
      cnt     <= '0;
      acc     <= '0;
      out_sum <= '0;
      out_sat <= 1'b0;
`ifdef TERNARY_DOT_SAT_EN
      sat_acc <= 1'b0;
`endif
    end else if (accept) begin
      if (cnt == LAST_CNT) begin
        state   <= DONE;
        out_sum <= sum_c;
        out_sat <= sat_c;
        cnt     <= '0;
        acc     <= '0;
`ifdef TERNARY_DOT_SAT_EN
        sat_acc <= 1'b0;
`endif
      end else begin
        state <= ACCUM;
        cnt   <= cnt + CNT_W'(1);
        acc   <= sum_c;
`ifdef TERNARY_DOT_SAT_EN
        sat_acc <= sat_c;
`endif
      end
    end else if ((state == DONE) && out_ready) begin
      state <= ACCUM;
    end
  end

endmodule

// File: tb/tb_ternary_dot_stream.sv
// Self-checking bench for ternary_dot_stream: directed vectors plus a bursty random phase,
// all results checked against a queue-based reference model every cycle.
module tb_ternary_dot_stream;

  localparam int unsigned N     = 32;
  localparam int unsigned BEATS = 4;
  localparam int unsigned ACC_W = 8;
  localparam longint MAXV = (longint'(1) << (ACC_W - 1)) - 1;
  localparam longint MINV = -(longint'(1) << (ACC_W - 1));
  localparam longint MODV = longint'(1) << ACC_W;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_w_pos;
  logic [N-1:0]     in_w_neg;
  logic [N-1:0]     in_x;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_sat;

  ternary_dot_stream #(.N(N), .BEATS(BEATS), .ACC_W(ACC_W)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_w_pos  (in_w_pos),
    .in_w_neg  (in_w_neg),
    .in_x      (in_x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_sat   (out_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    longint sum;
    bit     sat;
  } res_t;

  res_t   exp_q[$];
  longint beats_q[$];
  int     n_pass  = 0;
  int     n_total = 0;
  bit     ev;
  bit     rnd_on  = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference: fold the whole vector of beat values with plain integer arithmetic
  function automatic res_t model_result();
    res_t   r;
    longint run = 0;
    bit     clamped = 1'b0;
    foreach (beats_q[i]) begin
      run += beats_q[i];
`ifdef TERNARY_DOT_SAT_EN
      if (run > MAXV) begin run = MAXV; clamped = 1'b1; end
      else if (run < MINV) begin run = MINV; clamped = 1'b1; end
`endif
    end
`ifndef TERNARY_DOT_SAT_EN
    run = ((run % MODV) + MODV) % MODV;
    if (run > MAXV) run -= MODV;
`endif
    r.sum = run;
    r.sat = clamped;
    return r;
  endfunction

  function automatic longint beat_value(input logic [N-1:0] wp, input logic [N-1:0] wn,
                                        input logic [N-1:0] x);
    return longint'($countones(wp & x & ~wn)) - longint'($countones(wn & x & ~wp));
  endfunction

  // Compare process: inputs change just after posedge, everything is sampled at negedge
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      beats_q.delete();
    end else begin
      ev = exp_q.size() != 0;
      chk("out_valid", longint'(out_valid), longint'(ev));
      chk("in_ready", longint'(in_ready), longint'(!ev || out_ready));
      if (ev && out_valid) begin
        chk("out_sum", longint'($signed(out_sum)), exp_q[0].sum);
        chk("out_sat", longint'(out_sat), longint'(exp_q[0].sat));
        if (out_ready) void'(exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        beats_q.push_back(beat_value(in_w_pos, in_w_neg, in_x));
        if (beats_q.size() == BEATS) begin
          exp_q.push_back(model_result());
          beats_q.delete();
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [N-1:0] wp, input logic [N-1:0] wn, input logic [N-1:0] x);
    bit got = 1'b0;
    in_valid = 1'b1;
    in_w_pos = wp;
    in_w_neg = wn;
    in_x     = x;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      got = in_ready;
      step();
    end
    in_valid = 1'b0;
    if (!got) begin
      n_total++;
      $display("FAIL send_timeout: in_ready never high, got 0 expected 1 at %0t", $time);
    end
  endtask

  task automatic wait_result(input string name, input longint exp_sum, input bit exp_sat);
    bit got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (out_valid) got = 1'b1;
      else step();
    end
    if (got) begin
      chk({name, "_sum"}, longint'($signed(out_sum)), exp_sum);
      chk({name, "_sat"}, longint'(out_sat), longint'(exp_sat));
      step();
    end else begin
      n_total++;
      $display("FAIL %s_timeout: out_valid got 0 expected 1 at %0t", name, $time);
    end
  endtask

  task automatic send_zeros(input int n);
    for (int i = 0; i < n; i++) send('0, '0, '0);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_w_pos  = '0;
    in_w_neg  = '0;
    in_x      = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_out_sum", longint'(out_sum), 0);
    chk("rst_out_sat", longint'(out_sat), 0);
    step();
    reset = 1'b0;

    // Basic: one full +32 beat then three zero beats
    send('1, '0, '1);
    send_zeros(3);
    wait_result("basic", 32, 1'b0);

    // Mixed masks with overlap lanes cancelling
    send(32'h0000FFFF, 32'h00FF00FF, 32'hFFFFFFFF);
    send_zeros(3);
    wait_result("mixed", 0, 1'b0);
    send(32'h0000FFFF, 32'h00FF00FF, 32'h0000FF00);
    send_zeros(3);
    wait_result("mixed_x", 8, 1'b0);

    // Backpressure: hold the result, then release together with a new beat
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(32'h1, '0, 32'h1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", longint'(out_valid), 1);
      chk("bp_out_sum", longint'($signed(out_sum)), 4);
      chk("bp_in_ready", longint'(in_ready), 0);
      step();
    end
    out_ready = 1'b1;
    send(32'h7, '0, 32'h7);
    send_zeros(3);
    wait_result("bp_next", 3, 1'b0);

    // Overflow of an 8-bit accumulator
    for (int i = 0; i < 4; i++) send('1, '0, '1);
`ifdef TERNARY_DOT_SAT_EN
    wait_result("ovf", 127, 1'b1);
`else
    wait_result("ovf", -128, 1'b0);
`endif
    send_zeros(4);
    wait_result("ovf_next", 0, 1'b0);

    // Reset mid-vector discards the partial result
    send(32'h1F, '0, 32'h1F);
    send(32'h1F, '0, 32'h1F);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", longint'(out_valid), 0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_no_result", longint'(out_valid), 0);
      step();
    end
    for (int i = 0; i < 4; i++) send(32'h1, '0, 32'h1);
    wait_result("midrst", 4, 1'b0);

    // Random: bursty valid/ready, checked by the compare process
    rnd_on = 1'b1;
    fork
      begin
        for (int v = 0; v < 1000; v++) begin
          for (int b = 0; b < int'(BEATS); b++) begin
            case ($urandom_range(0, 3))
              0:       send('1, '0, '1);
              1:       send('0, '1, '1);
              default: send(N'($urandom), N'($urandom), N'($urandom));
            endcase
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) step();
          end
        end
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          out_ready = ($urandom_range(0, 3) != 0);
          step();
        end
        out_ready = 1'b1;
      end
    join
    repeat (10) step();
    chk("drain_out_valid", longint'(out_valid), 0);
    chk("drain_pending", longint'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
